// File: rtl/steer_en_ctrl_if.sv
// Load-cell sample bus and steering-enable status grouped for steer_en_ctrl.
interface steer_en_ctrl_if #(
    parameter int unsigned LD_W = 12
);
    logic [LD_W-1:0] lft_ld;
    logic [LD_W-1:0] rght_ld;
    logic            vld;
    logic            en_steer;
    logic            rider_off;
    logic [1:0]      state_o;

    // Sample source side: drives load cells, observes the controller.
    modport master (
        output lft_ld,
        output rght_ld,
        output vld,
        input  en_steer,
        input  rider_off,
        input  state_o
    );

    // Controller side.
    modport slave (
        input  lft_ld,
        input  rght_ld,
        input  vld,
        output en_steer,
        output rider_off,
        output state_o
    );
endinterface

// File: rtl/steer_en_ctrl.sv
// Steering enable controller: qualifies rider presence and balance from two
// load cells, waits for a settle period, and debounces rider step-off.
module steer_en_ctrl #(
    parameter int unsigned LD_W         = 12,
    parameter int unsigned MIN_RIDER_WT = 12'h200,
    parameter int unsigned HYST         = 12'h040,
    parameter int unsigned TMR_CYCLES   = 65_000_000,
    parameter int unsigned OFF_DEB      = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    steer_en_ctrl_if.slave bus
);

    localparam int unsigned SUM_W = LD_W + 1;
    localparam int unsigned CMP_W = LD_W + 5;
    localparam int unsigned TMR_W = (TMR_CYCLES > 2) ? $clog2(TMR_CYCLES) : 1;
    localparam int unsigned DEB_W = (OFF_DEB > 2) ? $clog2(OFF_DEB) : 1;

    localparam logic [TMR_W-1:0] TMR_FULL = TMR_W'(TMR_CYCLES - 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(OFF_DEB - 1);
    localparam logic [CMP_W-1:0] HI_TH    = CMP_W'(MIN_RIDER_WT + HYST);
    // Lower bound clamps to zero, so sum_lt_min can never assert in that case.
    localparam logic [CMP_W-1:0] LO_TH    =
        (MIN_RIDER_WT >= HYST) ? CMP_W'(MIN_RIDER_WT - HYST) : '0;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        WAIT  = 2'b01,
        STEER = 2'b10
    } state_t;

    state_t           state, state_nxt;
    logic [TMR_W-1:0] tmr_q, tmr_nxt;
    logic [DEB_W-1:0] deb_q, deb_nxt;
    logic             en_steer_q, en_steer_nxt;
    logic             rider_off_q, rider_off_nxt;

    logic [SUM_W-1:0] sum;
    logic [LD_W-1:0]  diff;
    logic [CMP_W-1:0] sum_x, diff_x;
    logic             sum_gt_min, sum_lt_min;
    logic             diff_gt_eighth, diff_gt_15_16;

    // Weight sum, imbalance magnitude and threshold comparisons at full width.
    always_comb begin
        sum            = SUM_W'(bus.lft_ld) + SUM_W'(bus.rght_ld);
        diff           = (bus.lft_ld >= bus.rght_ld) ? (bus.lft_ld - bus.rght_ld)
                                                      : (bus.rght_ld - bus.lft_ld);
        sum_x          = CMP_W'(sum);
        diff_x         = CMP_W'(diff);
        sum_gt_min     = (sum_x > HI_TH);
        sum_lt_min     = (sum_x < LO_TH);
        diff_gt_eighth = ((diff_x << 3) > sum_x);
        diff_gt_15_16  = ((diff_x << 4) > (sum_x * CMP_W'(15)));
    end

    // State, timers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            tmr_q       <= '0;
            deb_q       <= '0;
            en_steer_q  <= 1'b0;
            rider_off_q <= 1'b0;
        end else begin
            state       <= state_nxt;
            tmr_q       <= tmr_nxt;
            deb_q       <= deb_nxt;
            en_steer_q  <= en_steer_nxt;
            rider_off_q <= rider_off_nxt;
        end
    end

    // Next-state, settle timer, step-off debounce and output decode.
    always_comb begin
        state_nxt     = state;
        tmr_nxt       = tmr_q;
        deb_nxt       = deb_q;
        rider_off_nxt = 1'b0;

        case (state)
            IDLE: begin
                if (bus.vld && sum_gt_min) begin
                    state_nxt = WAIT;
                    tmr_nxt   = '0;
                end
            end
            WAIT: begin
                if (bus.vld) begin
                    if (sum_lt_min) begin
                        state_nxt     = IDLE;
                        rider_off_nxt = 1'b1;
                    end else if (diff_gt_eighth) begin
                        tmr_nxt = '0;
                    end else if (tmr_q == TMR_FULL) begin
                        state_nxt = STEER;
                    end else begin
                        tmr_nxt = tmr_q + TMR_W'(1);
                    end
                end
            end
            STEER: begin
                if (bus.vld) begin
                    if (sum_lt_min) begin
                        state_nxt     = IDLE;
                        rider_off_nxt = 1'b1;
                        deb_nxt       = '0;
                    end else if (diff_gt_15_16) begin
                        if (deb_q == DEB_LAST) begin
                            state_nxt = WAIT;
                            tmr_nxt   = '0;
                            deb_nxt   = '0;
                        end else begin
                            deb_nxt = deb_q + DEB_W'(1);
                        end
                    end else begin
                        deb_nxt = '0;
                    end
                end
            end
            default: begin
                // Illegal encoding: recover silently to IDLE.
                state_nxt = IDLE;
                tmr_nxt   = '0;
                deb_nxt   = '0;
            end
        endcase

        en_steer_nxt = (state_nxt == STEER);
    end

    assign bus.en_steer  = en_steer_q;
    assign bus.rider_off = rider_off_q;
    assign bus.state_o   = state;

endmodule

// File: tb/tb_steer_en_ctrl.sv
// Directed bench for steer_en_ctrl with TMR_CYCLES=16, OFF_DEB=4.
module tb_steer_en_ctrl;

    localparam int unsigned LD_W = 12;
    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_WAIT  = 2'b01;
    localparam logic [1:0] S_STEER = 2'b10;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    steer_en_ctrl_if #(.LD_W(LD_W)) bus ();

    steer_en_ctrl #(
        .LD_W        (LD_W),
        .MIN_RIDER_WT(12'h200),
        .HYST        (12'h040),
        .TMR_CYCLES  (16),
        .OFF_DEB     (4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Apply one sample, clock it, and settle just after the edge.
    task automatic step(input logic [11:0] l, input logic [11:0] r, input logic v);
        bus.lft_ld  = l;
        bus.rght_ld = r;
        bus.vld     = v;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [1:0] st, input logic en, input logic ro);
        chk({tag, ".state"}, 32'(bus.state_o), 32'(st));
        chk({tag, ".en"}, 32'(bus.en_steer), 32'(en));
        chk({tag, ".ro"}, 32'(bus.rider_off), 32'(ro));
    endtask

    initial begin
        n_cmp       = 0;
        n_bad       = 0;
        rst_n       = 1'b0;
        bus.lft_ld  = '0;
        bus.rght_ld = '0;
        bus.vld     = 1'b0;

        #3;
        chk_out("reset", S_IDLE, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // First clock after release without vld stays in IDLE.
        step(12'h150, 12'h150, 1'b0);
        chk_out("post_rst_novld", S_IDLE, 1'b0, 1'b0);

        // Mount: WAIT next valid cycle, STEER after 16 more valid cycles.
        step(12'h150, 12'h150, 1'b1);
        chk_out("mount_wait", S_WAIT, 1'b0, 1'b0);
        for (int i = 1; i <= 15; i++) step(12'h150, 12'h150, 1'b1);
        chk_out("mount_15", S_WAIT, 1'b0, 1'b0);
        step(12'h150, 12'h150, 1'b1);
        chk_out("mount_16", S_STEER, 1'b1, 1'b0);

        // Dismount: sum 0x100 drops to IDLE with a single rider_off pulse.
        step(12'h080, 12'h080, 1'b1);
        chk_out("dismount", S_IDLE, 1'b0, 1'b1);
        step(12'h080, 12'h080, 1'b0);
        chk_out("dismount_ro_clr", S_IDLE, 1'b0, 1'b0);
        step(12'h080, 12'h080, 1'b1);
        chk_out("dismount_idle", S_IDLE, 1'b0, 1'b0);

        // Unbalanced mount: imbalance on WAIT cycle 10 restarts the timer twice.
        step(12'h150, 12'h150, 1'b1);
        chk_out("unbal_wait", S_WAIT, 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 9; i++) step(12'h150, 12'h150, 1'b1);
            step(12'h1A0, 12'h100, 1'b1);
        end
        chk_out("unbal_hit", S_WAIT, 1'b0, 1'b0);
        for (int i = 1; i <= 15; i++) step(12'h150, 12'h150, 1'b1);
        chk_out("unbal_15", S_WAIT, 1'b0, 1'b0);
        step(12'h150, 12'h150, 1'b1);
        chk_out("unbal_16", S_STEER, 1'b1, 1'b0);

        // Step-off for 3 cycles is filtered.
        for (int i = 0; i < 3; i++) step(12'h280, 12'h008, 1'b1);
        chk_out("stepoff3", S_STEER, 1'b1, 1'b0);
        step(12'h150, 12'h150, 1'b1);
        chk_out("stepoff3_bal", S_STEER, 1'b1, 1'b0);

        // Step-off for 4 cycles returns to WAIT.
        for (int i = 0; i < 3; i++) step(12'h280, 12'h008, 1'b1);
        chk_out("stepoff4_3", S_STEER, 1'b1, 1'b0);
        step(12'h280, 12'h008, 1'b1);
        chk_out("stepoff4", S_WAIT, 1'b0, 1'b0);

        // vld gating: 5 valid, 20 frozen, then 11 more valid to reach STEER.
        for (int i = 0; i < 5; i++) step(12'h150, 12'h150, 1'b1);
        for (int i = 0; i < 20; i++) step(12'h150, 12'h150, 1'b0);
        chk_out("vld_frozen", S_WAIT, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(12'h150, 12'h150, 1'b1);
        chk_out("vld_resume10", S_WAIT, 1'b0, 1'b0);
        step(12'h150, 12'h150, 1'b1);
        chk_out("vld_resume11", S_STEER, 1'b1, 1'b0);

        // Hysteresis band in STEER: 0x1D0 / 0x230 keep STEER.
        for (int i = 0; i < 3; i++) begin
            step(12'h0E8, 12'h0E8, 1'b1);
            step(12'h118, 12'h118, 1'b1);
        end
        chk_out("hyst_steer", S_STEER, 1'b1, 1'b0);

        // Same stimulus from IDLE keeps IDLE.
        step(12'h080, 12'h080, 1'b1);
        chk_out("hyst_exit", S_IDLE, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(12'h0E8, 12'h0E8, 1'b1);
            step(12'h118, 12'h118, 1'b1);
        end
        chk_out("hyst_idle", S_IDLE, 1'b0, 1'b0);

        // Reset mid-STEER: asynchronous drop, no rider_off.
        step(12'h150, 12'h150, 1'b1);
        for (int i = 0; i < 16; i++) step(12'h150, 12'h150, 1'b1);
        chk_out("remount", S_STEER, 1'b1, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        chk_out("async_rst", S_IDLE, 1'b0, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(12'h150, 12'h150, 1'b0);
        chk_out("after_rst", S_IDLE, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/steer_en_ctrl.md
STEER_EN_CTRL -- requirements
Module: steer_en_ctrl

Interface
REQ-001 SHALL have parameter LD_W, default 12: load-cell sample width, unsigned.
REQ-002 SHALL have parameter MIN_RIDER_WT, default 12'h200: minimum rider weight, compared against the load-cell sum.
REQ-003 SHALL have parameter HYST, default 12'h040: weight hysteresis half-band.
REQ-004 SHALL have parameter TMR_CYCLES, default 65_000_000: settle time in clk cycles (1.3 s at 50 MHz).
REQ-005 SHALL have parameter OFF_DEB, default 8: consecutive cycles of diff_gt_15_16 needed to leave STEER.
REQ-006 SHALL have port clk, input, 1 bit: 50 MHz clock.
REQ-007 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-008 SHALL have port lft_ld, input, LD_W bits: left load cell.
REQ-009 SHALL have port rght_ld, input, LD_W bits: right load cell.
REQ-010 SHALL have port vld, input, 1 bit: load samples valid this cycle.
REQ-011 SHALL have port en_steer, output, 1 bit: steering enabled, registered.
REQ-012 SHALL have port rider_off, output, 1 bit: one-cycle pulse on return to IDLE.
REQ-013 SHALL have port state_o, output, 2 bits: current state, for debug.

Function
REQ-014 SHALL compute sum = lft_ld + rght_ld at LD_W+1 bits, with no overflow.
REQ-015 SHALL compute diff = |lft_ld - rght_ld| at LD_W bits.
REQ-016 SHALL set sum_gt_min = (sum > MIN_RIDER_WT + HYST) and sum_lt_min = (sum < MIN_RIDER_WT - HYST); if MIN_RIDER_WT < HYST, the lower bound clamps to 0 and sum_lt_min never asserts.
REQ-017 SHALL set diff_gt_eighth = (8*diff > sum) and diff_gt_15_16 = (16*diff > 15*sum), evaluated at LD_W+5 bits with no truncation.
REQ-018 SHALL update the FSM and counters only in cycles with vld=1; when vld=0 all state, timers and outputs hold, except that rider_off still deasserts after its pulse.
REQ-019 SHALL use states IDLE=2'b00, WAIT=2'b01, STEER=2'b10; encoding 2'b11 is illegal and goes to IDLE on the next clock with no rider_off pulse.
REQ-020 SHALL, in IDLE: on sum_gt_min, go to WAIT and clear the settle timer; otherwise stay in IDLE.
REQ-021 SHALL, in WAIT, apply these rules in priority order: sum_lt_min goes to IDLE; diff_gt_eighth clears the timer and stays in WAIT; timer full goes to STEER; otherwise the timer increments and the FSM stays in WAIT.
REQ-022 SHALL, in STEER, apply these rules in priority order: sum_lt_min goes to IDLE immediately; OFF_DEB consecutive valid cycles of diff_gt_15_16 go to WAIT, clearing the settle timer; otherwise stay in STEER.
REQ-023 SHALL count diff_gt_15_16 consecutive cycles in a debounce counter that clears on any valid cycle without diff_gt_15_16 and on any exit from STEER.
REQ-024 SHALL define the settle timer as $clog2(TMR_CYCLES) bits, with "full" meaning count == TMR_CYCLES-1 and the count saturating there.
REQ-025 SHALL therefore enter STEER exactly TMR_CYCLES valid cycles after the last timer clear, when the WAIT path is undisturbed.
REQ-026 SHALL register en_steer as (next_state==STEER), so it is high in the same cycle state_o reads STEER.
REQ-027 SHALL register rider_off high for exactly one clk in the cycle after a WAIT->IDLE or STEER->IDLE transition.
REQ-028 SHALL give sum_lt_min priority over diff conditions when both are true in the same cycle.
REQ-029 SHALL keep sum_gt_min and sum_lt_min mutually exclusive; a sum inside the hysteresis band keeps the current state, resetting nothing in STEER and counting normally in WAIT.

Reset
REQ-030 SHALL, on rst_n low, asynchronously set state=IDLE, en_steer=0, rider_off=0, settle timer=0, debounce counter=0.
REQ-031 SHALL, on reset asserted mid-STEER, drop en_steer in the same cycle asynchronously and produce no rider_off pulse.
REQ-032 SHALL remain in IDLE on the first clock after reset release unless vld=1 and sum_gt_min.

Verification (LD_W=12, MIN=0x200, HYST=0x40, TMR_CYCLES=16, OFF_DEB=4)
REQ-033 SHALL be verified for mount: vld=1, lft=rght=0x150 (sum 0x2A0), held -> WAIT next cycle, STEER with en_steer=1 after 16 valid cycles.
REQ-034 SHALL be verified for unbalanced mount: lft=0x1A0, rght=0x100 (8*0xA0 > 0x2A0) repeatedly on cycle 10 of WAIT -> timer restarts, and STEER arrives 16 cycles after the last imbalance.
REQ-035 SHALL be verified for step-off debounce: in STEER, lft=0x280, rght=0x008 for 3 cycles then balanced -> stays STEER; the same for 4 cycles -> WAIT, en_steer=0.
REQ-036 SHALL be verified for dismount: in STEER, sum drops to 0x100 -> IDLE next cycle, rider_off=1 for exactly one cycle, en_steer=0.
REQ-037 SHALL be verified for the hysteresis band: sum oscillating between 0x1D0 and 0x230 while in STEER -> remains STEER; from IDLE, the same stimulus -> remains IDLE.
REQ-038 SHALL be verified for vld gating and reset: vld=0 for 20 cycles during WAIT -> timer frozen; rst_n pulse mid-STEER -> IDLE, all outputs 0, no rider_off pulse.
